// File: rtl/master_pkg.sv
`timescale 1ns/1ps
// master_pkg: state encodings, field widths and bus-phase helper shared by the I2C master and slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package master_pkg;

    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_RW    = 3'd3,
        ST_ACK1  = 3'd4,
        ST_DATA  = 3'd5,
        ST_ACK2  = 3'd6,
        ST_STOP  = 3'd7
    } state_e;

    // Plain constants so legacy code can compare against a bare 3-bit state vector.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_RW    = 3'd3;
    localparam logic [2:0] S_ACK1  = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;
    localparam logic [2:0] S_ACK2  = 3'd6;
    localparam logic [2:0] S_STOP  = 3'd7;

    // Bit-counter value of the last bit in each shifted field (counter starts at 0).
    localparam logic [2:0] LAST_ADDR_BIT = 3'(ADDR_BITS - 1);
    localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

    // SCL toggles only while bits (or ACK slots) are being clocked on the bus.
    function automatic logic scl_running(input logic [2:0] st);
        return (st == S_ADDR) || (st == S_RW) || (st == S_ACK1) ||
               (st == S_DATA) || (st == S_ACK2);
    endfunction

endpackage

// File: rtl/master_scl_gen.sv
`timescale 1ns/1ps
// master_scl_gen: gates the I2C clock; inverted i2c_clk while enabled, parked high otherwise.
// Latency: combinational, zero cycles.
// Backpressure: none.
module master_scl_gen (
    input  logic i2c_clk,
    input  logic enable,
    output logic scl
);

    // Inversion puts the SCL falling edge on the i2c_clk rising edge, where SDA changes,
    // so SDA is already stable when SCL rises mid-cycle.
    assign scl = enable ? ~i2c_clk : 1'b1;

endmodule

// File: rtl/master.sv
`timescale 1ns/1ps
// master: one-shot I2C write (START, 7-bit address, R/W, ACK, data byte, ACK, STOP); optional MASTER_ACK_CHECK_EN.
// Latency: a fully acknowledged transaction spans 22 i2c_clk cycles after reset release.
// Backpressure: none; with MASTER_ACK_CHECK_EN an address NACK cuts straight to STOP.
module master
    import master_pkg::*;
#(
    parameter logic [ADDR_BITS-1:0] ADDR = 7'b1101001,
    parameter logic [DATA_BITS-1:0] DATA = 8'b10101010,
    parameter logic                 RW   = 1'b0
) (
    input  logic       i2c_clk,
    input  logic       reset,
    inout  wire        sda_line,
    output logic       scl,
    output logic [2:0] state_out
);

`ifdef MASTER_ACK_CHECK_EN
    localparam logic ACK_CHECK = 1'b1;
`else
    localparam logic ACK_CHECK = 1'b0;
`endif

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic       done;
    logic       done_nxt;
    logic       sda_oe;
    logic       sda_out;
    logic       addr_ack;

    // Only a solid 0 counts as ACK; a floating or unknown line falls to the NACK branch.
    assign addr_ack = (sda_line == 1'b0);

    // Next-state, bit-counter and one-shot flag logic.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt + 3'd1;
        done_nxt    = done;
        case (state)
            S_IDLE: begin
                if (!done) begin
                    state_nxt = S_START;
                end
            end
            S_START: state_nxt = S_ADDR;
            S_ADDR: begin
                if (bit_cnt == LAST_ADDR_BIT) begin
                    state_nxt = S_RW;
                end
            end
            S_RW:   state_nxt = S_ACK1;
            S_ACK1: begin
                if (addr_ack || !ACK_CHECK) begin
                    state_nxt = S_DATA;
                end else begin
                    state_nxt = S_STOP;
                end
            end
            S_DATA: begin
                if (bit_cnt == LAST_DATA_BIT) begin
                    state_nxt = S_ACK2;
                end
            end
            S_ACK2: state_nxt = S_STOP;
            S_STOP: begin
                if (bit_cnt == 3'd1) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Every state entry restarts the count; IDLE holds it at zero so a parked
        // master never lets the counter wrap.
        if ((state_nxt != state) || (state == S_IDLE)) begin
            bit_cnt_nxt = 3'd0;
        end
    end

    // State, counter and done registers; reset aborts instantly with no STOP.
    always_ff @(posedge i2c_clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            done    <= done_nxt;
        end
    end

    // SDA source per state: fields go out MSB first, ACK slots release the line.
    always_comb begin
        sda_oe  = 1'b1;
        sda_out = 1'b1;
        case (state)
            S_START: sda_out = 1'b0;
            S_ADDR:  sda_out = ADDR[LAST_ADDR_BIT - bit_cnt];
            S_RW:    sda_out = RW;
            S_ACK1:  sda_oe  = 1'b0;
            S_DATA:  sda_out = DATA[LAST_DATA_BIT - bit_cnt];
            S_ACK2:  sda_oe  = 1'b0;
            // Low for the first STOP cycle, then high while SCL is high: the STOP edge.
            S_STOP:  sda_out = bit_cnt[0];
            default: sda_out = 1'b1;
        endcase
    end

    assign sda_line  = sda_oe ? sda_out : 1'bz;
    assign state_out = state;

    master_scl_gen u_scl_gen (
        .i2c_clk (i2c_clk),
        .enable  (scl_running(state)),
        .scl     (scl)
    );

endmodule

// File: tb/tb_master.sv
`timescale 1ns/1ps
// tb_master: two masters (default and overridden parameters) against behavioural slaves and a
// transaction-level model of the expected per-cycle state / SDA trace.
// Runs reset hold, full write, address NACK and mid-transfer reset scenarios.
module tb_master;

    localparam logic [2:0] T_IDLE  = 3'd0;
    localparam logic [2:0] T_START = 3'd1;
    localparam logic [2:0] T_ADDR  = 3'd2;
    localparam logic [2:0] T_RW    = 3'd3;
    localparam logic [2:0] T_ACK1  = 3'd4;
    localparam logic [2:0] T_DATA  = 3'd5;
    localparam logic [2:0] T_ACK2  = 3'd6;
    localparam logic [2:0] T_STOP  = 3'd7;

    localparam logic [6:0] A0 = 7'b1101001;
    localparam logic [7:0] D0 = 8'b10101010;
    localparam logic [6:0] A1 = 7'h2A;
    localparam logic [7:0] D1 = 8'h5C;

`ifdef MASTER_ACK_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    logic       i2c_clk = 1'b0;
    logic       reset   = 1'b0;
    wire        sda0;
    wire        sda1;
    logic       scl0;
    logic       scl1;
    logic [2:0] st0;
    logic [2:0] st1;

    // Behavioural slave side: drive enables/values and captured fields.
    logic       drv0 = 1'b0;
    logic       drv1 = 1'b0;
    logic       dv0  = 1'b1;
    logic       dv1  = 1'b1;
    logic       ack1v [2];
    logic       ack2v [2];
    int         cnt [2];
    logic [6:0] addr_cap [2];
    logic       rw_cap [2];
    logic [7:0] data_cap [2];

    // Expected trace per cycle: {state, bus SDA value}.
    logic [3:0] exp_q0 [$];
    logic [3:0] exp_q1 [$];

    int checks = 0;
    int errors = 0;

    master u_m0 (
        .i2c_clk   (i2c_clk),
        .reset     (reset),
        .sda_line  (sda0),
        .scl       (scl0),
        .state_out (st0)
    );

    master #(.ADDR(A1), .DATA(D1)) u_m1 (
        .i2c_clk   (i2c_clk),
        .reset     (reset),
        .sda_line  (sda1),
        .scl       (scl1),
        .state_out (st1)
    );

    assign sda0 = drv0 ? dv0 : 1'bz;
    assign sda1 = drv1 ? dv1 : 1'bz;

    always #50 i2c_clk = ~i2c_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Slave: bits 1-7 address, 8 R/W, 9 ACK slot, 10-17 data, 18 ACK slot.
    task automatic slave_bit(input int k, input logic b);
        cnt[k]++;
        if (cnt[k] <= 7) addr_cap[k] = {addr_cap[k][5:0], b};
        else if (cnt[k] == 8) rw_cap[k] = b;
        else if (cnt[k] >= 10 && cnt[k] <= 17) data_cap[k] = {data_cap[k][6:0], b};
    endtask

    always @(posedge scl0) slave_bit(0, sda0);
    always @(posedge scl1) slave_bit(1, sda1);

    // Answer the ACK slot for one i2c_clk period (1 emulates the pull-up, i.e. NACK).
    always @(negedge scl0) begin
        if (cnt[0] == 8 || cnt[0] == 17) begin
            #5;
            dv0  = (cnt[0] == 8) ? ack1v[0] : ack2v[0];
            drv0 = 1'b1;
            @(posedge i2c_clk);
            #5;
            drv0 = 1'b0;
        end
    end

    always @(negedge scl1) begin
        if (cnt[1] == 8 || cnt[1] == 17) begin
            #5;
            dv1  = (cnt[1] == 8) ? ack1v[1] : ack2v[1];
            drv1 = 1'b1;
            @(posedge i2c_clk);
            #5;
            drv1 = 1'b0;
        end
    end

    task automatic clear_slaves();
        for (int k = 0; k < 2; k++) begin
            cnt[k]      = 0;
            addr_cap[k] = '0;
            rw_cap[k]   = 1'b0;
            data_cap[k] = '0;
        end
        drv0 = 1'b0;
        drv1 = 1'b0;
    endtask

    task automatic push(input int k, input logic [2:0] st, input logic b);
        if (k == 0) exp_q0.push_back({st, b});
        else exp_q1.push_back({st, b});
    endtask

    // Transaction as a phase list: IDLE, START, address, R/W, ACK, [data, ACK], STOP.
    task automatic build_model(input int k, input logic [6:0] a, input logic [7:0] d,
                               input logic r, input logic a1, input logic a2);
        if (k == 0) exp_q0.delete();
        else exp_q1.delete();
        push(k, T_IDLE, 1'b1);
        push(k, T_START, 1'b0);
        for (int b = 6; b >= 0; b--) push(k, T_ADDR, a[b]);
        push(k, T_RW, r);
        push(k, T_ACK1, a1);
        if (!(CHECK_EN && a1)) begin
            for (int b = 7; b >= 0; b--) push(k, T_DATA, d[b]);
            push(k, T_ACK2, a2);
        end
        push(k, T_STOP, 1'b0);
        push(k, T_STOP, 1'b1);
    endtask

    function automatic logic [3:0] exp_at(input int k, input int i);
        if (k == 0) return (i < exp_q0.size()) ? exp_q0[i] : {T_IDLE, 1'b1};
        return (i < exp_q1.size()) ? exp_q1[i] : {T_IDLE, 1'b1};
    endfunction

    // i2c_clk high: SCL must be low in bus phases, high otherwise.
    task automatic check_high(input int i);
        logic [3:0] e;
        logic       es;
        for (int k = 0; k < 2; k++) begin
            e  = exp_at(k, i);
            es = (e[3:1] >= T_ADDR && e[3:1] <= T_ACK2) ? 1'b0 : 1'b1;
            chk($sformatf("scl_hi m%0d c%0d", k, i), 8'(k == 0 ? scl0 : scl1), 8'(es));
        end
    endtask

    // i2c_clk low: SCL high in every state; state and SDA must match the trace.
    task automatic check_low(input int i);
        logic [3:0] e;
        for (int k = 0; k < 2; k++) begin
            e = exp_at(k, i);
            chk($sformatf("state m%0d c%0d", k, i), 8'(k == 0 ? st0 : st1), 8'(e[3:1]));
            chk($sformatf("sda m%0d c%0d", k, i), 8'(k == 0 ? sda0 : sda1), 8'(e[0]));
            chk($sformatf("scl_lo m%0d c%0d", k, i), 8'(k == 0 ? scl0 : scl1), 8'h01);
        end
    endtask

    task automatic check_cycle(input int i);
        @(posedge i2c_clk);
        #10;
        check_high(i);
        @(negedge i2c_clk);
        #10;
        check_low(i);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, " state0"}, 8'(st0), 8'h00);
        chk({tag, " scl0"}, 8'(scl0), 8'h01);
        chk({tag, " sda0"}, 8'(sda0), 8'h01);
        chk({tag, " state1"}, 8'(st1), 8'h00);
        chk({tag, " scl1"}, 8'(scl1), 8'h01);
        chk({tag, " sda1"}, 8'(sda1), 8'h01);
    endtask

    task automatic check_capture(input string tag, input int k, input logic [6:0] a,
                                 input logic [7:0] d);
        chk({tag, " addr"}, 8'(addr_cap[k]), 8'(a));
        chk({tag, " rw"}, 8'(rw_cap[k]), 8'h00);
        chk({tag, " data"}, data_cap[k], d);
    endtask

    initial begin
        // Reset held low for 200 ns with the clock running.
        reset = 1'b0;
        #10;
        for (int s = 0; s < 10; s++) begin
            reset_check($sformatf("rst_hold t%0d", s));
            #20;
        end

        // Full acknowledged write, then parked in IDLE out to 10 us.
        ack1v[0] = 1'b0;
        ack1v[1] = 1'b0;
        ack2v[0] = 1'($urandom_range(0, 1));
        ack2v[1] = 1'($urandom_range(0, 1));
        build_model(0, A0, D0, 1'b0, ack1v[0], ack2v[0]);
        build_model(1, A1, D1, 1'b0, ack1v[1], ack2v[1]);
        clear_slaves();
        @(negedge i2c_clk);
        reset = 1'b1;
        #10;
        check_low(0);
        for (int i = 1; i < 100; i++) check_cycle(i);
        check_capture("write m0", 0, A0, D0);
        check_capture("write m1", 1, A1, D1);

        // Address NACK on master 0, random answer on master 1.
        reset = 1'b0;
        #1;
        clear_slaves();
        reset_check("nack_rst");
        ack1v[0] = 1'b1;
        ack1v[1] = 1'($urandom_range(0, 1));
        ack2v[0] = 1'($urandom_range(0, 1));
        ack2v[1] = 1'($urandom_range(0, 1));
        build_model(0, A0, D0, 1'b0, ack1v[0], ack2v[0]);
        build_model(1, A1, D1, 1'b0, ack1v[1], ack2v[1]);
        repeat ($urandom_range(1, 4)) @(negedge i2c_clk);
        reset = 1'b1;
        #10;
        check_low(0);
        for (int i = 1; i < 30; i++) check_cycle(i);
        check_capture("nack m0", 0, A0, CHECK_EN ? 8'h00 : D0);
        check_capture("nack m1", 1, A1, (CHECK_EN && ack1v[1]) ? 8'h00 : D1);

        // Reset during the third data bit, then a complete rerun.
        reset = 1'b0;
        #1;
        clear_slaves();
        ack1v[0] = 1'b0;
        ack1v[1] = 1'b0;
        ack2v[0] = 1'b0;
        ack2v[1] = 1'b0;
        build_model(0, A0, D0, 1'b0, 1'b0, 1'b0);
        build_model(1, A1, D1, 1'b0, 1'b0, 1'b0);
        @(negedge i2c_clk);
        reset = 1'b1;
        #10;
        check_low(0);
        for (int i = 1; i < 13; i++) check_cycle(i);
        @(posedge i2c_clk);
        #10;
        check_high(13);
        reset = 1'b0;
        #1;
        reset_check("mid_rst");
        clear_slaves();
        repeat (2) @(negedge i2c_clk);
        reset = 1'b1;
        #10;
        check_low(0);
        for (int i = 1; i < 30; i++) check_cycle(i);
        check_capture("rerun m0", 0, A0, D0);
        check_capture("rerun m1", 1, A1, D1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
